// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat dealer.
//   state_t       : round sequencing states
//   card_t        : one card code (0 = blank, 1..13 = A..K)
//   NATURAL_MIN   : a two-card score at or above this ends the round
//   DRAW_MAX      : a two-card score at or below this draws a third card
//   rank_value()  : point value of a card (10, J, Q, K count as 0)
//   banker_draws(): banker third-card decision once the player has drawn
package baccarat_pkg;

    typedef enum logic [3:0] {
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        DECIDE,
        DEAL_P3,
        BANKER_RULE,
        DEAL_D3,
        FINISH
    } state_t;

    typedef logic [3:0] card_t;

    localparam logic [3:0] NATURAL_MIN = 4'd8;
    localparam logic [3:0] DRAW_MAX    = 4'd5;

    function automatic logic [3:0] rank_value(input card_t c);
        return (c >= 4'd10) ? 4'd0 : c;
    endfunction

    // bscore is the banker's two-card score, v the value of the player's
    // third card.
    function automatic logic banker_draws(input logic [3:0] bscore,
                                          input logic [3:0] v);
        logic draw;
        draw = 1'b0;
        case (bscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

endpackage

// File: rtl/deck_counter.sv
// Free-running card source: counts 1, 2, ..., DECK_SIZE, 1, ... on every
// clock. Synchronous active-high reset returns it to 1.
//   clk   in   clock
//   srst  in   synchronous reset, active high
//   deck  out  current rank code (registered)
module deck_counter
    import baccarat_pkg::*;
#(
    parameter int DECK_SIZE = 13,
    parameter int CARD_W    = 4
) (
    input  logic              clk,
    input  logic              srst,
    output logic [CARD_W-1:0] deck
);

    logic [CARD_W-1:0] deck_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            deck_reg <= CARD_W'(1);
        end else if (deck_reg == CARD_W'(DECK_SIZE)) begin
            deck_reg <= CARD_W'(1);
        end else begin
            deck_reg <= deck_reg + CARD_W'(1);
        end
    end

    assign deck = deck_reg;

endmodule

// File: rtl/baccarat_dealer.sv
// Sequencing FSM for one baccarat round. Cards are drawn from a free-running
// deck counter into three player and three banker card registers in deal
// order; external scorers return pscore/dscore, from which the natural and
// third-card rules are applied and the winner is flagged.
//
// Optional feature macro: DEALER_FORCE_CARD_EN
//   When defined, force_valid/force_card ports are added; a dealing step with
//   force_valid=1 loads force_card instead of the deck value (the deck keeps
//   counting). When undefined, cards come only from the deck.
//
// Ports:
//   slow_clock   in   clock, all state changes on the rising edge
//   reset        in   synchronous, active-high
//   step         in   deals one card per cycle while in a DEAL_* state
//   pscore       in   player score 0..9
//   dscore       in   banker score 0..9
//   force_valid  in   (DEALER_FORCE_CARD_EN only) use force_card for this deal
//   force_card   in   (DEALER_FORCE_CARD_EN only) card code to load
//   pcard1..3    out  player cards, 0 = blank
//   dcard1..3    out  banker cards, 0 = blank
//   player_win   out  player score >= banker score, valid with done
//   dealer_win   out  banker score >= player score, valid with done
//   done         out  round complete
module baccarat_dealer
    import baccarat_pkg::*;
#(
    parameter int DECK_SIZE = 13,
    parameter int CARD_W    = 4
) (
    input  logic              slow_clock,
    input  logic              reset,
    input  logic              step,
    input  logic [3:0]        pscore,
    input  logic [3:0]        dscore,
`ifdef DEALER_FORCE_CARD_EN
    input  logic              force_valid,
    input  logic [CARD_W-1:0] force_card,
`endif
    output logic [CARD_W-1:0] pcard1,
    output logic [CARD_W-1:0] pcard2,
    output logic [CARD_W-1:0] pcard3,
    output logic [CARD_W-1:0] dcard1,
    output logic [CARD_W-1:0] dcard2,
    output logic [CARD_W-1:0] dcard3,
    output logic              player_win,
    output logic              dealer_win,
    output logic              done
);

    // Card slots in deal order: P1, D1, P2, D2, P3, D3.
    localparam int NUM_CARDS = 6;

    state_t            state_reg;
    logic [CARD_W-1:0] deck;
    logic [CARD_W-1:0] deal_value;
    logic              deal_en;
    logic [2:0]        deal_slot;
    logic [CARD_W-1:0] card_reg [NUM_CARDS];

    deck_counter #(
        .DECK_SIZE (DECK_SIZE),
        .CARD_W    (CARD_W)
    ) u_deck (
        .clk  (slow_clock),
        .srst (reset),
        .deck (deck)
    );

`ifdef DEALER_FORCE_CARD_EN
    assign deal_value = force_valid ? force_card : deck;
`else
    assign deal_value = deck;
`endif

    // Which card register the current state deals into; steps outside the
    // DEAL_* states leave deal_en low and are ignored.
    always_comb begin
        deal_en   = 1'b0;
        deal_slot = 3'd0;
        case (state_reg)
            DEAL_P1: begin deal_en = step; deal_slot = 3'd0; end
            DEAL_D1: begin deal_en = step; deal_slot = 3'd1; end
            DEAL_P2: begin deal_en = step; deal_slot = 3'd2; end
            DEAL_D2: begin deal_en = step; deal_slot = 3'd3; end
            DEAL_P3: begin deal_en = step; deal_slot = 3'd4; end
            DEAL_D3: begin deal_en = step; deal_slot = 3'd5; end
            default: begin deal_en = 1'b0; deal_slot = 3'd0; end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CARDS; gi++) begin : g_card
            always_ff @(posedge slow_clock) begin
                if (reset) begin
                    card_reg[gi] <= '0;
                end else if (deal_en && (deal_slot == 3'(gi))) begin
                    card_reg[gi] <= deal_value;
                end
            end
        end
    endgenerate

    assign pcard1 = card_reg[0];
    assign dcard1 = card_reg[1];
    assign pcard2 = card_reg[2];
    assign dcard2 = card_reg[3];
    assign pcard3 = card_reg[4];
    assign dcard3 = card_reg[5];

    // Scores are only read in DECIDE, BANKER_RULE and FINISH, each of which
    // is entered at least one cycle after the last card load, so the external
    // scorers always see the registered cards. The win flags are computed in
    // FINISH itself so that a banker third card dealt on the way in is counted.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_reg  <= DEAL_P1;
            done       <= 1'b0;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
        end else begin
            case (state_reg)
                DEAL_P1: if (step) state_reg <= DEAL_D1;
                DEAL_D1: if (step) state_reg <= DEAL_P2;
                DEAL_P2: if (step) state_reg <= DEAL_D2;
                DEAL_D2: if (step) state_reg <= DECIDE;
                DECIDE: begin
                    if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                        state_reg <= FINISH;
                    end else if (pscore <= DRAW_MAX) begin
                        state_reg <= DEAL_P3;
                    end else if (dscore <= DRAW_MAX) begin
                        state_reg <= DEAL_D3;
                    end else begin
                        state_reg <= FINISH;
                    end
                end
                DEAL_P3: if (step) state_reg <= BANKER_RULE;
                BANKER_RULE: begin
                    if (banker_draws(dscore, rank_value(card_t'(card_reg[4])))) begin
                        state_reg <= DEAL_D3;
                    end else begin
                        state_reg <= FINISH;
                    end
                end
                DEAL_D3: if (step) state_reg <= FINISH;
                FINISH: begin
                    done       <= 1'b1;
                    player_win <= (pscore >= dscore);
                    dealer_win <= (dscore >= pscore);
                end
                default: state_reg <= DEAL_P1;
            endcase
        end
    end

endmodule
